// File: rtl/video_line_scaler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : video_line_scaler_pkg
// Brief    : Shared types and helpers for the video line scaler.
// Revision : 1.0 - initial release
// ============================================================================
package video_line_scaler_pkg;

    // Width of the runtime repeat-factor port and repeat counter.
    localparam int c_REP_W = 2;

    // Control bits that travel alongside a RAM read so the output stage can
    // blank or dim the pixel once the registered read data arrives.
    typedef struct packed {
        logic blank;
        logic dim;
    } rd_ctl_t;

    // Effective repeat factor: 0 behaves as 1, anything above the build-time
    // maximum is clamped to that maximum.
    function automatic logic [c_REP_W-1:0] f_rep_eff(
        input logic [c_REP_W-1:0] rep,
        input logic [c_REP_W-1:0] max_rep
    );
        logic [c_REP_W-1:0] r;
        if (rep == '0) begin
            r = c_REP_W'(1);
        end else if (rep > max_rep) begin
            r = max_rep;
        end else begin
            r = rep;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_line_scaler_ram.sv
`default_nettype none
// ============================================================================
// Module   : video_line_scaler_ram
// Brief    : Simple dual-port line RAM, one write port and one read port with
//            a single-cycle registered read. Holds all line banks flat.
// Revision : 1.0 - initial release
// ============================================================================
module video_line_scaler_ram #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 896,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array: write when enabled, register read data only on a read so
    // the output holds between requests.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/video_line_scaler.sv
`default_nettype none
// ============================================================================
// Module   : video_line_scaler
// Brief    : Line-buffer scaler. Input lines are written into a ring of line
//            banks; each stored line is replayed a runtime number of times,
//            optionally dimmed on its final repeat. Sticky flags report input
//            lines that are too long and reads that catch up with the writer.
// Revision : 1.0 - initial release
// ============================================================================
module video_line_scaler #(
    parameter int COLOR_W  = 6,
    parameter int CH_W     = 2,
    parameter int LINE_LEN = 448,
    parameter int NBUF     = 2,
    parameter int MAX_REP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         rep,
    input  logic               dim_en,
    input  logic               scanin_start,
    input  logic               pix_in_stb,
    input  logic [COLOR_W-1:0] pix_in,
    input  logic               scanout_start,
    input  logic               pix_out_stb,
    output logic [COLOR_W-1:0] pix_out,
    input  logic               flags_clr,
    output logic               wr_ovf,
    output logic               rd_udr
);

    import video_line_scaler_pkg::*;

    // Counters must be able to hold LINE_LEN itself (the "line full" value).
    localparam int c_CNT_W     = $clog2(LINE_LEN + 1);
    localparam int c_BANK_W    = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int c_RAM_DEPTH = NBUF * LINE_LEN;
    localparam int c_RAM_AW    = $clog2(c_RAM_DEPTH);

    localparam logic [c_CNT_W-1:0]  c_LEN     = c_CNT_W'(LINE_LEN);
    localparam logic [c_REP_W-1:0]  c_MAX_REP = c_REP_W'(MAX_REP);
    localparam logic [c_BANK_W-1:0] c_BANK_RST = c_BANK_W'(NBUF - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_BANK_W-1:0] wbank_q, wbank_d;          // bank being written
    logic [c_CNT_W-1:0]  waddr_q, waddr_d;          // next write pixel
    logic [c_BANK_W-1:0] rbank_q, rbank_d;          // bank for the next pass
    logic [c_BANK_W-1:0] pass_bank_q, pass_bank_d;  // bank of the current pass
    logic [c_CNT_W-1:0]  raddr_q, raddr_d;          // next read pixel
    logic [c_REP_W-1:0]  rep_cnt_q, rep_cnt_d;      // passes done on rbank
    logic                last_q, last_d;            // current pass is a dimmable final repeat
    logic [c_CNT_W-1:0]  len_q [NBUF];              // pixels written per bank
    logic [c_CNT_W-1:0]  len_d [NBUF];
    logic                wr_ovf_q, wr_ovf_d;
    logic                rd_udr_q, rd_udr_d;
    rd_ctl_t             rd_ctl_q, rd_ctl_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [c_BANK_W-1:0] w_wr_bank;
    logic [c_CNT_W-1:0]  w_wr_addr;
    logic                w_wr_en;
    logic                w_ovf_set;

    logic [c_REP_W-1:0]  w_rep_eff;
    logic [c_REP_W:0]    w_pass_num;
    logic                w_rep_done;
    logic [c_BANK_W-1:0] w_rbank_nxt;
    logic                w_udr_set;
    logic [c_BANK_W-1:0] w_rd_bank;
    logic [c_CNT_W-1:0]  w_rd_addr;
    logic                w_rd_last;
    logic                w_rd_hit;
    logic                w_rd_en;

    logic [c_RAM_AW-1:0] w_wr_ram_addr;
    logic [c_RAM_AW-1:0] w_rd_ram_addr;
    logic [COLOR_W-1:0]  w_ram_q;
    logic [COLOR_W-1:0]  w_pix_dim;

    // Flat RAM address of a pixel within a bank.
    function automatic logic [c_RAM_AW-1:0] f_ram_addr(
        input logic [c_BANK_W-1:0] bank,
        input logic [c_CNT_W-1:0]  addr
    );
        return c_RAM_AW'(bank) * c_RAM_AW'(LINE_LEN) + c_RAM_AW'(addr);
    endfunction

    // Write side: bank switch on line start, pixel placement, overflow drop,
    // and the per-bank written-length bookkeeping.
    always_comb begin
        wbank_d   = wbank_q;
        waddr_d   = waddr_q;
        w_wr_bank = wbank_q;
        w_wr_addr = waddr_q;
        len_d     = len_q;

        // A pixel arriving with the line-start strobe lands at address 0 of
        // the freshly selected bank.
        if (scanin_start) begin
            wbank_d        = wbank_q + c_BANK_W'(1);
            waddr_d        = '0;
            w_wr_bank      = wbank_d;
            w_wr_addr      = '0;
            len_d[wbank_d] = '0;
        end

        w_wr_en   = pix_in_stb && (w_wr_addr < c_LEN);
        w_ovf_set = pix_in_stb && !w_wr_en;

        if (w_wr_en) begin
            waddr_d          = w_wr_addr + c_CNT_W'(1);
            len_d[w_wr_bank] = waddr_d;
        end
    end

    // Read side: pass start, repeat counting, bank advance with underrun
    // protection, and the per-request read address / blank / dim decision.
    always_comb begin
        rbank_d     = rbank_q;
        pass_bank_d = pass_bank_q;
        raddr_d     = raddr_q;
        rep_cnt_d   = rep_cnt_q;
        last_d      = last_q;
        rd_ctl_d    = rd_ctl_q;
        w_udr_set   = 1'b0;

        w_rep_eff   = f_rep_eff(rep, c_MAX_REP);
        w_pass_num  = {1'b0, rep_cnt_q} + (c_REP_W + 1)'(1);
        w_rep_done  = (w_pass_num >= {1'b0, w_rep_eff});
        w_rbank_nxt = rbank_q + c_BANK_W'(1);

        w_rd_bank   = pass_bank_q;
        w_rd_addr   = raddr_q;
        w_rd_last   = last_q;

        // The pass plays rbank as it stands; rbank moves on only once this
        // pass completes the repeat count. The collision check uses the
        // write bank before any same-cycle line start.
        if (scanout_start) begin
            pass_bank_d = rbank_q;
            raddr_d     = '0;
            last_d      = w_rep_done && (w_rep_eff > c_REP_W'(1));
            if (w_rep_done) begin
                rep_cnt_d = '0;
                if (w_rbank_nxt == wbank_q) begin
                    w_udr_set = 1'b1;
                end else begin
                    rbank_d = w_rbank_nxt;
                end
            end else begin
                rep_cnt_d = w_pass_num[c_REP_W-1:0];
            end
            w_rd_bank = rbank_q;
            w_rd_addr = '0;
            w_rd_last = last_d;
        end

        // Only pixels actually written to this bank are valid; everything
        // past that (including past LINE_LEN) reads as blank.
        w_rd_hit = (w_rd_addr < len_q[w_rd_bank]);
        w_rd_en  = pix_out_stb && w_rd_hit;

        if (pix_out_stb) begin
            rd_ctl_d.blank = !w_rd_hit;
            rd_ctl_d.dim   = dim_en && w_rd_last;
            if (w_rd_addr < c_LEN) begin
                raddr_d = w_rd_addr + c_CNT_W'(1);
            end
        end
    end

    // Sticky flags: a same-cycle set beats a clear.
    always_comb begin
        wr_ovf_d = w_ovf_set | (wr_ovf_q & ~flags_clr);
        rd_udr_d = w_udr_set | (rd_udr_q & ~flags_clr);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank_q     <= '0;
            waddr_q     <= '0;
            rbank_q     <= c_BANK_RST;
            pass_bank_q <= c_BANK_RST;
            raddr_q     <= '0;
            rep_cnt_q   <= '0;
            last_q      <= 1'b0;
            for (int b = 0; b < NBUF; b++) begin
                len_q[b] <= '0;
            end
            wr_ovf_q    <= 1'b0;
            rd_udr_q    <= 1'b0;
            rd_ctl_q    <= '{blank: 1'b1, dim: 1'b0};
        end else begin
            wbank_q     <= wbank_d;
            waddr_q     <= waddr_d;
            rbank_q     <= rbank_d;
            pass_bank_q <= pass_bank_d;
            raddr_q     <= raddr_d;
            rep_cnt_q   <= rep_cnt_d;
            last_q      <= last_d;
            len_q       <= len_d;
            wr_ovf_q    <= wr_ovf_d;
            rd_udr_q    <= rd_udr_d;
            rd_ctl_q    <= rd_ctl_d;
        end
    end

    assign w_wr_ram_addr = f_ram_addr(w_wr_bank, w_wr_addr);
    assign w_rd_ram_addr = f_ram_addr(w_rd_bank, w_rd_addr);

    video_line_scaler_ram #(
        .WIDTH (COLOR_W),
        .DEPTH (c_RAM_DEPTH),
        .AW    (c_RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_ram_addr),
        .i_wdata (pix_in),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_ram_addr),
        .o_rdata (w_ram_q)
    );

    // Scanline dimming: each colour channel is halved independently.
    generate
        for (genvar g = 0; g < COLOR_W / CH_W; g++) begin : g_ch
            if (CH_W > 1) begin : g_shift
                assign w_pix_dim[g*CH_W +: CH_W] = {1'b0, w_ram_q[g*CH_W+1 +: CH_W-1]};
            end else begin : g_zero
                assign w_pix_dim[g*CH_W] = 1'b0;
            end
        end
    endgenerate

    // Output select: every input here is a register (RAM read data and the
    // read-control bits captured with it), so pix_out changes only on a
    // clock edge or on reset, which forces blank immediately.
    always_comb begin
        if (rd_ctl_q.blank) begin
            pix_out = '0;
        end else if (rd_ctl_q.dim) begin
            pix_out = w_pix_dim;
        end else begin
            pix_out = w_ram_q;
        end
    end

    assign wr_ovf = wr_ovf_q;
    assign rd_udr = rd_udr_q;

endmodule
`default_nettype wire

// File: tb/tb_video_line_scaler.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_line_scaler
// Brief    : Self-checking bench for video_line_scaler with an expected-pixel
//            scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_line_scaler;

    localparam int COLOR_W  = 6;
    localparam int LINE_LEN = 448;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         rep;
    logic               dim_en;
    logic               scanin_start;
    logic               pix_in_stb;
    logic [COLOR_W-1:0] pix_in;
    logic               scanout_start;
    logic               pix_out_stb;
    logic [COLOR_W-1:0] pix_out;
    logic               flags_clr;
    logic               wr_ovf;
    logic               rd_udr;

    int n_chk  = 0;
    int n_pass = 0;
    logic [COLOR_W-1:0] exp_q [$];

    video_line_scaler #(
        .COLOR_W  (COLOR_W),
        .CH_W     (2),
        .LINE_LEN (LINE_LEN),
        .NBUF     (2),
        .MAX_REP  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rep           (rep),
        .dim_en        (dim_en),
        .scanin_start  (scanin_start),
        .pix_in_stb    (pix_in_stb),
        .pix_in        (pix_in),
        .scanout_start (scanout_start),
        .pix_out_stb   (pix_out_stb),
        .pix_out       (pix_out),
        .flags_clr     (flags_clr),
        .wr_ovf        (wr_ovf),
        .rd_udr        (rd_udr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pixel pattern of a given test line.
    function automatic logic [5:0] pix_of(input int id, input int i);
        case (id)
            0:       return 6'(i % 64);
            1:       return 6'h3F;
            default: return 6'(((i * 5 + id * 11 + 1) % 63) + 1);
        endcase
    endfunction

    // Halve each 2-bit channel of an RRGGBB pixel.
    function automatic logic [5:0] dim6(input logic [5:0] p);
        return {1'b0, p[5], 1'b0, p[3], 1'b0, p[1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input int id, input int n, input bit same_cycle);
        int first;
        first = 0;
        scanin_start = 1'b1;
        if (same_cycle) begin
            pix_in_stb = 1'b1;
            pix_in     = pix_of(id, 0);
            first      = 1;
        end
        tick();
        scanin_start = 1'b0;
        for (int i = first; i < n; i++) begin
            pix_in_stb = 1'b1;
            pix_in     = pix_of(id, i);
            tick();
        end
        pix_in_stb = 1'b0;
    endtask

    task automatic start_pass();
        scanout_start = 1'b1;
        tick();
        scanout_start = 1'b0;
    endtask

    // Request n_read pixels; the first n_data are expected to be line `id`,
    // the rest blank. Expected values go into the scoreboard when the request
    // is driven and come out when the output is sampled one clock later.
    task automatic read_pass(input string tag, input int id, input int n_data,
                             input int n_read, input bit dim);
        for (int i = 0; i < n_read; i++) begin
            logic [5:0] e;
            e = (i < n_data) ? pix_of(id, i) : 6'd0;
            if (dim) e = dim6(e);
            exp_q.push_back(e);
            pix_out_stb = 1'b1;
            tick();
            check(tag, pix_out, exp_q.pop_front());
        end
        pix_out_stb = 1'b0;
    endtask

    task automatic clear_flags();
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        rep           = 2'd2;
        dim_en        = 1'b0;
        scanin_start  = 1'b0;
        pix_in_stb    = 1'b0;
        pix_in        = '0;
        scanout_start = 1'b0;
        pix_out_stb   = 1'b0;
        flags_clr     = 1'b0;
        tick();
        tick();
        check("rst_pix", pix_out, 0);
        check("rst_ovf", wr_ovf, 0);
        check("rst_udr", rd_udr, 0);
        rst = 1'b0;
        tick();

        // rep=2, no dim: full-length ramp line played twice, then past end.
        write_line(0, LINE_LEN, 1'b0);
        start_pass();
        read_pass("r2_pass1", 0, LINE_LEN, LINE_LEN, 1'b0);
        tick();
        tick();
        check("hold_idle", pix_out, 6'd63);
        start_pass();
        check("hold_start", pix_out, 6'd63);
        read_pass("r2_pass2", 0, LINE_LEN, LINE_LEN + 2, 1'b0);
        check("r2_ovf", wr_ovf, 0);
        check("r2_udr", rd_udr, 0);

        // rep=3 (clamped to 2) with dim: final repeat halves each channel.
        rep    = 2'd3;
        dim_en = 1'b1;
        write_line(1, 4, 1'b0);
        start_pass();
        read_pass("dim_pass1", 1, 4, 5, 1'b0);
        start_pass();
        read_pass("dim_pass2", 1, 4, 4, 1'b1);
        check("dim_udr", rd_udr, 0);

        // rep=1 / rep=0: three lines at 1:1 rate, never dimmed.
        rep = 2'd1;
        write_line(2, 16, 1'b0);
        start_pass();
        read_pass("r1_A", 2, 16, 16, 1'b0);
        write_line(3, 16, 1'b1);
        start_pass();
        read_pass("r1_B", 3, 16, 16, 1'b0);
        rep = 2'd0;
        write_line(4, 16, 1'b0);
        start_pass();
        read_pass("r1_C", 4, 16, 17, 1'b0);
        check("r1_ovf", wr_ovf, 0);
        check("r1_udr", rd_udr, 0);
        dim_en = 1'b0;
        rep    = 2'd1;

        // Overflow: pixels beyond LINE_LEN are dropped and flagged.
        write_line(5, LINE_LEN, 1'b0);
        check("ovf_at_len", wr_ovf, 0);
        for (int i = LINE_LEN; i < LINE_LEN + 2; i++) begin
            pix_in_stb = 1'b1;
            pix_in     = pix_of(5, i);
            tick();
        end
        pix_in_stb = 1'b0;
        check("ovf_set", wr_ovf, 1);
        pix_in_stb = 1'b1;
        flags_clr  = 1'b1;
        tick();
        pix_in_stb = 1'b0;
        flags_clr  = 1'b0;
        check("ovf_set_wins", wr_ovf, 1);
        clear_flags();
        check("ovf_clr", wr_ovf, 0);
        start_pass();
        read_pass("ovf_line", 5, LINE_LEN, LINE_LEN + 2, 1'b0);
        check("ovf_udr", rd_udr, 0);

        // Underrun: four output lines per input line. The second pass would
        // step onto the bank being written, so the previous bank (holding the
        // overflow line) is replayed from then on.
        write_line(6, 8, 1'b0);
        start_pass();
        read_pass("udr_p1", 6, 8, 8, 1'b0);
        check("udr_p1_flag", rd_udr, 0);
        start_pass();
        read_pass("udr_p2", 5, 8, 8, 1'b0);
        check("udr_p2_flag", rd_udr, 1);
        start_pass();
        read_pass("udr_p3", 5, 8, 8, 1'b0);
        start_pass();
        read_pass("udr_p4", 5, 8, 8, 1'b0);
        check("udr_p4_flag", rd_udr, 1);
        clear_flags();
        check("udr_clr", rd_udr, 0);

        // Simultaneous line starts: the advance check sees the old write bank.
        scanin_start  = 1'b1;
        scanout_start = 1'b1;
        tick();
        scanin_start  = 1'b0;
        scanout_start = 1'b0;
        check("simul_udr", rd_udr, 1);

        // Reset mid-line: output blanks at once, state returns to reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        write_line(7, 8, 1'b0);
        start_pass();
        read_pass("pre_rst", 7, 8, 3, 1'b0);
        pix_out_stb = 1'b1;
        rst         = 1'b1;
        #1;
        check("rst_async_pix", pix_out, 0);
        check("rst_async_udr", rd_udr, 0);
        tick();
        check("rst_hold_pix", pix_out, 0);
        rst         = 1'b0;
        pix_out_stb = 1'b0;
        tick();
        read_pass("rst_blank", 0, 0, 3, 1'b0);
        write_line(8, 3, 1'b0);
        start_pass();
        read_pass("rst_short", 8, 3, 5, 1'b0);
        check("end_ovf", wr_ovf, 0);
        check("end_udr", rd_udr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
